// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic tile controller.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DRAIN,
        COLLECT,
        READOUT,
        DONE
    } tile_state_e;

    // Skewed operands need 2N-1 shifts to fully enter an N x N array.
    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_tile_controller_phase_counter.sv
// Loadable down-counter with terminal-count flag.
// Times the FEED, DRAIN and COLLECT phases.
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/systolic_tile_controller.sv
// Control sequencer for one systolic tile: LOAD, FEED, DRAIN, COLLECT, READOUT, DONE.
// Optional cycle counter output tile_cycles enabled by TILE_CTRL_PERF_EN.
module systolic_tile_controller #(
    parameter int ARRAY_SIZE   = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 8,
    localparam int PTR_W       = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sb_write,
    output logic [PTR_W-1:0] sb_row_ptr,
    output logic             sb_enable,
    output logic             pe_enable,
    output logic             rsb_write,
    output logic             rsb_enable,
    output logic             rsb_read,
    output logic             out_valid,
    input  logic             out_ready
`ifdef TILE_CTRL_PERF_EN
   ,output logic [31:0]      tile_cycles
`endif
);

    import systolic_ctrl_pkg::*;

    // Counter is loaded with (length - 1) and the phase ends on terminal count.
    localparam logic [CNT_W-1:0] FEED_LOAD    = CNT_W'(feed_cycles(ARRAY_SIZE) - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD   = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] COLLECT_LOAD = CNT_W'(ARRAY_SIZE - 1);
    localparam logic [PTR_W-1:0] LAST_BEAT    = PTR_W'(ARRAY_SIZE - 1);

    // Handshakes: a beat transfers on a clock edge where valid and ready are both high;
    // ready is decoded from state only and never depends on valid.
    tile_state_e      state, next_state;
    logic [PTR_W-1:0] beat_cnt;
    logic             beat_inc, beat_clr;
    logic             pc_load, pc_dec, pc_tc;
    logic [CNT_W-1:0] pc_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        beat_inc   = 1'b0;
        beat_clr   = 1'b0;
        pc_load    = 1'b0;
        pc_value   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    beat_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (beat_cnt == LAST_BEAT) begin
                        next_state = FEED;
                        beat_clr   = 1'b1;
                        pc_load    = 1'b1;
                        pc_value   = FEED_LOAD;
                    end else begin
                        beat_inc = 1'b1;
                    end
                end
            end
            FEED: begin
                if (pc_tc) begin
                    pc_load = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        next_state = COLLECT;
                        pc_value   = COLLECT_LOAD;
                    end else begin
                        next_state = DRAIN;
                        pc_value   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (pc_tc) begin
                    next_state = COLLECT;
                    pc_load    = 1'b1;
                    pc_value   = COLLECT_LOAD;
                end
            end
            COLLECT: begin
                if (pc_tc) begin
                    next_state = READOUT;
                end
            end
            READOUT: begin
                if (out_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        next_state = DONE;
                    end else begin
                        beat_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shared by LOAD (row pointer) and READOUT (result beats).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (beat_clr) begin
            beat_cnt <= '0;
        end else if (beat_inc) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign pc_dec = (state == FEED) || (state == DRAIN) || (state == COLLECT);

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_value(pc_value),
        .dec       (pc_dec),
        .tc        (pc_tc)
    );

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign in_ready   = (state == LOAD);
    assign sb_write   = in_valid & in_ready;
    assign sb_row_ptr = (state == LOAD) ? beat_cnt : '0;
    assign sb_enable  = (state == FEED);
    assign pe_enable  = (state == FEED) || (state == DRAIN) || (state == COLLECT);
    assign rsb_write  = (state == COLLECT);
    assign rsb_enable = (state == COLLECT);
    assign out_valid  = (state == READOUT);
    assign rsb_read   = out_valid & out_ready;

`ifdef TILE_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_next;

    assign perf_next = (&perf_cnt) ? perf_cnt : perf_cnt + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt    <= '0;
            tile_cycles <= '0;
        end else begin
            if ((state == IDLE) && (next_state == LOAD)) begin
                perf_cnt <= '0;
            end else if ((state != IDLE) && (state != DONE)) begin
                perf_cnt <= perf_next;
            end
            // The edge entering DONE still counts as a tile cycle.
            if ((next_state == DONE) && (state != DONE)) begin
                tile_cycles <= perf_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Self-checking bench for systolic_tile_controller: per-cycle timing windows,
// row-pointer scoreboard, stalls, back-to-back tiles and async abort.
module tb_systolic_tile_controller;

    localparam int N     = 4;
    localparam int DRAIN = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic             sb_write;
    logic [PTR_W-1:0] sb_row_ptr;
    logic             sb_enable;
    logic             pe_enable;
    logic             rsb_write;
    logic             rsb_enable;
    logic             rsb_read;
    logic             out_valid;
    logic             out_ready;
`ifdef TILE_CTRL_PERF_EN
    logic [31:0]      tile_cycles;
`endif

    systolic_tile_controller #(
        .ARRAY_SIZE  (N),
        .DRAIN_CYCLES(DRAIN),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sb_write   (sb_write),
        .sb_row_ptr (sb_row_ptr),
        .sb_enable  (sb_enable),
        .pe_enable  (pe_enable),
        .rsb_write  (rsb_write),
        .rsb_enable (rsb_enable),
        .rsb_read   (rsb_read),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef TILE_CTRL_PERF_EN
       ,.tile_cycles(tile_cycles)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int in_st;
        int in_len;
        int out_st;
        int out_len;
        int mid_start;
        int abort_at;
        int exp_done;
        int exp_perf;
    } vec_t;

    vec_t             vecs[8];
    logic [PTR_W-1:0] exp_q[$];
    int               n_checks;
    int               n_pass;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_stalled(input int c, input vec_t v);
        return (v.in_len > 0) && (c >= v.in_st) && (c < v.in_st + v.in_len);
    endfunction

    function automatic bit out_stalled(input int c, input vec_t v);
        return (v.out_len > 0) && (c >= v.out_st) && (c < v.out_st + v.out_len);
    endfunction

    // Expected {busy,done,in_ready,sb_write,ptr[1:0],sb_en,pe_en,rsb_wr,rsb_en,rsb_rd,out_valid}
    // for cycle c, derived from the phase windows of a tile started at edge 0.
    function automatic logic [11:0] exp_vec(input int c, input vec_t v);
        logic             b, d, ir, sw, se, pe, rw, re, rr, ov;
        logic [PTR_W-1:0] ptr;
        int               le, fe, r0, rend, acc;
        {b, d, ir, sw, se, pe, rw, re, rr, ov} = '0;
        ptr  = '0;
        le   = N + v.in_len;
        fe   = le + 2 * N - 1;
        r0   = fe + DRAIN + N + 1;
        rend = r0 + N - 1 + v.out_len;
        if (c >= 1 && c <= le) begin
            b   = 1'b1;
            ir  = 1'b1;
            sw  = !in_stalled(c, v);
            acc = 0;
            for (int k = 1; k < c; k++) if (!in_stalled(k, v)) acc++;
            ptr = acc[PTR_W-1:0];
        end else if (c > le && c <= fe) begin
            {b, se, pe} = 3'b111;
        end else if (c > fe && c <= fe + DRAIN) begin
            {b, pe} = 2'b11;
        end else if (c > fe + DRAIN && c < r0) begin
            {b, pe, rw, re} = 4'b1111;
        end else if (c >= r0 && c <= rend) begin
            {b, ov} = 2'b11;
            rr = !out_stalled(c, v);
        end else if (c == rend + 1) begin
            {b, d} = 2'b11;
        end
        return {b, d, ir, sw, ptr, se, pe, rw, re, rr, ov};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {busy, done, in_ready, sb_write, sb_row_ptr, sb_enable, pe_enable,
                rsb_write, rsb_enable, rsb_read, out_valid};
    endfunction

    // driver + monitor for one tile; cycle 0 is the IDLE cycle in which start is driven
    task automatic run_tile(input vec_t v);
        logic [11:0]      ev;
        logic [PTR_W-1:0] got;
        int               n_wr, n_rd, n_done, done_cyc, acc;
        n_wr = 0; n_rd = 0; n_done = 0; done_cyc = -1; acc = 0;
        exp_q.delete();
        for (int c = 0; c <= v.exp_done; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (c == v.mid_start) || (c == v.exp_done);
            in_valid  = !in_stalled(c, v);
            out_ready = !out_stalled(c, v);
            ev = exp_vec(c, v);
            if (ev[8]) begin
                exp_q.push_back(acc[PTR_W-1:0]);
                acc++;
            end
            @(negedge clk);
            check($sformatf("tile%0d_outs", v.id), c, 32'(obs_vec()), 32'(ev));
            if (sb_write) begin
                n_wr++;
                check($sformatf("tile%0d_sb_q_avail", v.id), c, 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check($sformatf("tile%0d_sb_row_ptr", v.id), c, 32'(sb_row_ptr), 32'(got));
                end
            end
            if (rsb_read) n_rd++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == v.abort_at) begin
                #1 rst = 1'b0;
                #1 check($sformatf("tile%0d_async_rst_outs", v.id), c, 32'(obs_vec()), 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check($sformatf("tile%0d_idle_after_rst", v.id), c, 32'(busy), 32'd0);
                return;
            end
        end
        check($sformatf("tile%0d_writes", v.id), v.exp_done, 32'(n_wr), 32'(N));
        check($sformatf("tile%0d_reads", v.id), v.exp_done, 32'(n_rd), 32'(N));
        check($sformatf("tile%0d_done_pulses", v.id), v.exp_done, 32'(n_done), 32'd1);
        check($sformatf("tile%0d_done_cycle", v.id), v.exp_done, 32'(done_cyc), 32'(v.exp_done));
        check($sformatf("tile%0d_sb_q_drained", v.id), v.exp_done, 32'(exp_q.size()), 32'd0);
`ifdef TILE_CTRL_PERF_EN
        @(negedge clk);
        check($sformatf("tile%0d_tile_cycles", v.id), v.exp_done, tile_cycles, 32'(v.exp_perf));
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;

        //            id in_st in_len out_st out_len mid abort done perf
        vecs[0] = '{0, 0, 0, 0,  0, 0, -1, 24, 23};  // nominal
        vecs[1] = '{1, 3, 3, 0,  0, 0, -1, 27, 26};  // input stall after row 1
        vecs[2] = '{2, 0, 0, 21, 2, 0, -1, 26, 25};  // output backpressure
        vecs[3] = '{3, 0, 0, 0,  0, 7, -1, 24, 23};  // start during FEED ignored
        vecs[4] = '{4, 0, 0, 0,  0, 0, -1, 24, 23};  // back-to-back after tile 3
        vecs[5] = '{5, 0, 0, 0,  0, 0,  8, 24, 23};  // async reset in FEED
        vecs[6] = '{6, 0, 0, 0,  0, 0, -1, 24, 23};  // nominal after abort
        vecs[7] = '{7, 4, 2, 23, 1, 0, -1, 27, 26};  // combined stalls

        // reset state, checked while reset is held
        #12;
        check("rst_busy", 0, 32'(busy), 32'd0);
        check("rst_done", 0, 32'(done), 32'd0);
        check("rst_in_ready", 0, 32'(in_ready), 32'd0);
        check("rst_sb_write", 0, 32'(sb_write), 32'd0);
        check("rst_sb_row_ptr", 0, 32'(sb_row_ptr), 32'd0);
        check("rst_sb_enable", 0, 32'(sb_enable), 32'd0);
        check("rst_pe_enable", 0, 32'(pe_enable), 32'd0);
        check("rst_rsb_write", 0, 32'(rsb_write), 32'd0);
        check("rst_rsb_enable", 0, 32'(rsb_enable), 32'd0);
        check("rst_rsb_read", 0, 32'(rsb_read), 32'd0);
        check("rst_out_valid", 0, 32'(out_valid), 32'd0);
`ifdef TILE_CTRL_PERF_EN
        check("rst_tile_cycles", 0, tile_cycles, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_no_start", 0, 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_tile(vecs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
